gravity_flip_ctrl: RTL
======================

GRAVITY_FLIP_CTRL -- requirements
Module: gravity_flip_ctrl

Interface
REQ-001 Parameter NUM_LINES, default 3, number of platform lines (>=2).
REQ-002 Parameter H_W, default 9, height bus width.
REQ-003 Parameter LINE_Y0, default 120, down-gravity contact height of line 0.
REQ-004 Parameter LINE_PITCH, default 120, vertical spacing between lines.
REQ-005 Parameter LINE_THICK, default 60, offset from down-contact to up-contact on the same line.
REQ-006 Parameter BUF_CYC, default 4, press-buffer window in cycles (0 = no buffering).
REQ-007 Parameter COOLDOWN, default 8, post-flip lockout in cycles.
REQ-008 Parameter CNT_W, default 8, flip counter width.
REQ-009 clk  in  1  single clock; all state changes on rising edge.
REQ-010 reset  in  1  synchronous, active-high reset.
REQ-011 is_dead  in  1  high freezes all block state.
REQ-012 switch  in  1  player flip button (level).
REQ-013 lines  in  NUM_LINES  bit i high = line i present at player column.
REQ-014 height  in  H_W  player vertical position.
REQ-015 dir  out  1  0 = downward (normal) gravity, 1 = upward (reversed).
REQ-016 flip  out  1  one-cycle pulse in the cycle following a dir toggle.
REQ-017 flip_cnt  out  CNT_W  total flips since reset, saturating.
REQ-018 busy  out  1  high while in COOLDOWN.

Function
REQ-019 down_h(i) = LINE_Y0 + i*LINE_PITCH; up_h(i) = LINE_Y0 + LINE_THICK + (i-1)*LINE_PITCH; computed at elaboration, H_W bits.
REQ-020 on_line (combinational): dir=0 -> any i in 0..NUM_LINES-2 with lines[i] and height==down_h(i); dir=1 -> any i in 1..NUM_LINES-1 with lines[i] and height==up_h(i).
REQ-021 switch_q registers switch every cycle, including while is_dead=1; rise = switch & ~switch_q.
REQ-022 FSM states IDLE, ARMED, COOL; encoding is implementer's choice.
REQ-023 IDLE: rise & on_line -> toggle dir, load cool_cnt=COOLDOWN, go COOL; rise & ~on_line & BUF_CYC>0 -> load buf_cnt=BUF_CYC-1, go ARMED; otherwise stay.
REQ-024 ARMED: on_line -> toggle dir, load cool_cnt, go COOL; else rise -> reload buf_cnt=BUF_CYC-1; else buf_cnt==0 -> IDLE; else buf_cnt decrements.
REQ-025 COOL: cool_cnt==0 -> IDLE, else decrement; rises in COOL are discarded, not buffered.
REQ-026 COOLDOWN=0: COOL lasts exactly one cycle.
REQ-027 Every dir toggle asserts flip for exactly the next cycle and increments flip_cnt by 1; flip_cnt holds at 2^CNT_W-1.
REQ-028 Latency: rise with on_line sampled at edge k -> dir toggled after edge k, flip high between edges k and k+1.
REQ-029 is_dead=1: dir, FSM state, buf_cnt, cool_cnt, flip_cnt held; flip forced 0; no toggle.
REQ-030 is_dead=1 takes priority over any flip condition in the same cycle.
REQ-031 busy = (state==COOL), registered-state derived, no combinational path from inputs.

Reset
REQ-032 reset=1 at a clock edge: dir=0, state=IDLE, buf_cnt=0, cool_cnt=0, flip=0, flip_cnt=0, switch_q=1 (switch held through reset does not cause a flip).
REQ-033 reset overrides is_dead and any in-progress ARMED/COOL operation.

Verification
REQ-034 Defaults; dir=0, height=120, lines=3'b001, switch 0->1 -> dir=1 after that edge, flip one cycle, flip_cnt=1, busy high 9 cycles.
REQ-035 dir=1, height=300, lines=3'b100, press -> dir=0; same press at height=240 (down-contact line) with dir=1 -> no flip.
REQ-036 dir=0, press at height=119, height=120 with lines[0]=1 two cycles later -> flip (buffered); height reaches 120 five cycles after press -> no flip, state IDLE.
REQ-037 Press during COOL, contact held -> no flip until a new rise after busy falls; then flip, flip_cnt=2.
REQ-038 is_dead=1 with valid press and contact -> dir, flip_cnt unchanged, flip=0; deassert is_dead while switch still high -> no flip.
REQ-039 CNT_W=2, five valid flips -> flip_cnt sequence 1,2,3,3,3; reset asserted mid-COOL with switch=1 -> all outputs zero, no flip on release of reset.

Source files
------------

// File: rtl/gravity_flip_ctrl.sv
// Gravity-flip controller: toggles gravity direction on a button press while the
// player touches a platform line, with a short press buffer and a post-flip lockout.
module gravity_flip_ctrl #(
  parameter int NUM_LINES  = 3,
  parameter int H_W        = 9,
  parameter int LINE_Y0    = 120,
  parameter int LINE_PITCH = 120,
  parameter int LINE_THICK = 60,
  parameter int BUF_CYC    = 4,
  parameter int COOLDOWN   = 8,
  parameter int CNT_W      = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 is_dead,
  input  logic                 switch,
  input  logic [NUM_LINES-1:0] lines,
  input  logic [H_W-1:0]       height,
  output logic                 dir,
  output logic                 flip,
  output logic [CNT_W-1:0]     flip_cnt,
  output logic                 busy
);

  localparam int unsigned NL     = NUM_LINES;
  localparam int          BUF_W  = (BUF_CYC > 1) ? $clog2(BUF_CYC) : 1;
  localparam int          COOL_W = (COOLDOWN > 0) ? $clog2(COOLDOWN + 1) : 1;
  localparam logic [BUF_W-1:0]  BUF_LOAD  = BUF_W'((BUF_CYC > 0) ? BUF_CYC - 1 : 0);
  localparam logic [COOL_W-1:0] COOL_LOAD = COOL_W'(COOLDOWN);

  typedef enum logic [1:0] {IDLE, ARMED, COOL} state_t;

  state_t            state;
  logic [BUF_W-1:0]  buf_cnt;
  logic [COOL_W-1:0] cool_cnt;
  logic              switch_q;
  logic              rise;
  logic              on_line;
  logic              do_flip;

  function automatic logic [H_W-1:0] down_h(input int unsigned i);
    return H_W'(LINE_Y0 + int'(i) * LINE_PITCH);
  endfunction

  function automatic logic [H_W-1:0] up_h(input int unsigned i);
    return H_W'(LINE_Y0 + LINE_THICK + (int'(i) - 1) * LINE_PITCH);
  endfunction

  assign rise = switch & ~switch_q;
  assign busy = (state == COOL);

  // Down gravity stands on lines 0..N-2, up gravity hangs from lines 1..N-1.
  always_comb begin
    on_line = 1'b0;
    if (!dir) begin
      for (int unsigned i = 0; i < NL - 1; i++)
        if (lines[i] && (height == down_h(i))) on_line = 1'b1;
    end else begin
      for (int unsigned i = 1; i < NL; i++)
        if (lines[i] && (height == up_h(i))) on_line = 1'b1;
    end
  end

  always_comb begin
    do_flip = 1'b0;
    if (state == IDLE && rise && on_line) do_flip = 1'b1;
    if (state == ARMED && on_line)        do_flip = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      dir      <= 1'b0;
      flip     <= 1'b0;
      flip_cnt <= '0;
      buf_cnt  <= '0;
      cool_cnt <= '0;
      switch_q <= 1'b1;
    end else begin
      switch_q <= switch;
      flip     <= 1'b0;
      if (!is_dead) begin
        if (do_flip) begin
          dir      <= ~dir;
          flip     <= 1'b1;
          cool_cnt <= COOL_LOAD;
          state    <= COOL;
          if (flip_cnt != '1) flip_cnt <= flip_cnt + 1'b1;
        end else begin
          unique case (state)
            IDLE: begin
              if (rise && BUF_CYC > 0) begin
                buf_cnt <= BUF_LOAD;
                state   <= ARMED;
              end
            end
            ARMED: begin
              if (rise)                buf_cnt <= BUF_LOAD;
              else if (buf_cnt == '0)  state   <= IDLE;
              else                     buf_cnt <= buf_cnt - 1'b1;
            end
            COOL: begin
              if (cool_cnt == '0) state    <= IDLE;
              else                cool_cnt <= cool_cnt - 1'b1;
            end
            default: state <= IDLE;
          endcase
        end
      end
    end
  end

endmodule
